// File: rtl/reflet_float_au.sv
// reflet_float_au_arbiter: round-robin sharing of one float AU between two requesters with watchdog abort
module reflet_float_au_arbiter #(
  parameter int float_size = 32,
  parameter int integer_size = 16,
  parameter int timeout = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_accept,
  input  logic [7:0]                req0_op,
  input  logic [7:0]                req1_op,
  input  logic [3*float_size-1:0]   req0_flt,
  input  logic [3*float_size-1:0]   req1_flt,
  input  logic [integer_size-1:0]   req0_int,
  input  logic [integer_size-1:0]   req1_int,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic                      rsp_err,
  output logic [float_size-1:0]     rsp_flt,
  output logic [integer_size-1:0]   rsp_int,
  output logic                      rsp_cmp,
  output logic                      au_enable,
  output logic [1:0]                au_ctrl_flag,
  output logic [5:0]                au_opcode,
  output logic [float_size-1:0]     au_flt_in1,
  output logic [float_size-1:0]     au_flt_in2,
  output logic [float_size-1:0]     au_flt_in3,
  output logic [integer_size-1:0]   au_int_in,
  input  logic                      au_ready,
  input  logic                      au_cmp_flag,
  input  logic [float_size-1:0]     au_flt_out,
  input  logic [integer_size-1:0]   au_int_out
);
  localparam int ww = $clog2(timeout + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, RESP} state_t;
  state_t state, next;
  logic last_grant, cur_id, g, grant, done;
  logic [ww-1:0] wdog;
  always_comb begin
    g = &req_valid ? ~last_grant : req_valid[1];
    grant = state == IDLE && |req_valid;
    req_accept = grant ? (g ? 2'b10 : 2'b01) : 2'b00;
    done = state == WAIT && (au_ready || wdog == ww'(timeout - 1));
    au_enable = state == SETTLE || state == WAIT;
    next = state == IDLE ? (grant ? SETTLE : IDLE) :
           state == SETTLE ? WAIT :
           state == WAIT ? (done ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cur_id <= 1'b0;
      wdog <= '0;
      {au_ctrl_flag, au_opcode} <= '0;
      {au_flt_in3, au_flt_in2, au_flt_in1} <= '0;
      au_int_in <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_err <= 1'b0;
      rsp_flt <= '0;
      rsp_int <= '0;
      rsp_cmp <= 1'b0;
    end else begin
      state <= next;
      rsp_valid <= done;
      // cleared outside WAIT so SETTLE always starts the count at zero
      wdog <= (state == WAIT && !done) ? wdog + 1'b1 : '0;
      if (grant) begin
        {au_ctrl_flag, au_opcode} <= g ? req1_op : req0_op;
        {au_flt_in3, au_flt_in2, au_flt_in1} <= g ? req1_flt : req0_flt;
        au_int_in <= g ? req1_int : req0_int;
        cur_id <= g;
        last_grant <= g;
      end
      if (done) begin
        rsp_id <= cur_id;
        rsp_err <= !au_ready;
        rsp_flt <= au_ready ? au_flt_out : '0;
        rsp_int <= au_ready ? au_int_out : '0;
        rsp_cmp <= au_ready && au_cmp_flag;
      end
    end
endmodule

// File: tb/tb_reflet_float_au_arbiter.sv
// tb_reflet_float_au_arbiter: table vectors, corner sequences and random traffic against a cycle-budget model
module tb_reflet_float_au_arbiter;
  localparam int FS = 32, IS = 16, TO = 8, LAT = 5;
  logic clk = 0, reset = 0;
  logic [1:0] req_valid = 0, req_accept;
  logic [7:0] req0_op = 0, req1_op = 0;
  logic [3*FS-1:0] req0_flt = 0, req1_flt = 0;
  logic [IS-1:0] req0_int = 0, req1_int = 0;
  logic rsp_valid, rsp_id, rsp_err, rsp_cmp;
  logic [FS-1:0] rsp_flt, au_flt_in1, au_flt_in2, au_flt_in3, au_flt_out;
  logic [IS-1:0] rsp_int, au_int_in, au_int_out;
  logic au_enable, au_ready, au_cmp_flag;
  logic [1:0] au_ctrl_flag;
  logic [5:0] au_opcode;
  int vectors = 0, miscompares = 0;
  int mode = 0;
  int stub_cnt = 0;
  int cyc = 0;
  bit pending = 0, p_id, p_err, last_g = 1, t_on = 0, t_err = 0;
  int p_acc, p_due, free_at = 0, n_acc = 0;
  logic [1:0] t_acc = 0;
  logic [119:0] p_ops;
  logic [FS+IS:0] p_res;

  always #5 clk = ~clk;

  reflet_float_au_arbiter #(.float_size(FS), .integer_size(IS), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_accept(req_accept),
    .req0_op(req0_op), .req1_op(req1_op), .req0_flt(req0_flt), .req1_flt(req1_flt),
    .req0_int(req0_int), .req1_int(req1_int), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_flt(rsp_flt), .rsp_int(rsp_int), .rsp_cmp(rsp_cmp),
    .au_enable(au_enable), .au_ctrl_flag(au_ctrl_flag), .au_opcode(au_opcode),
    .au_flt_in1(au_flt_in1), .au_flt_in2(au_flt_in2), .au_flt_in3(au_flt_in3),
    .au_int_in(au_int_in), .au_ready(au_ready), .au_cmp_flag(au_cmp_flag),
    .au_flt_out(au_flt_out), .au_int_out(au_int_out));

  // AU stub: mode 0 = ready after LAT enabled cycles, 1 = always ready, 2 = never ready
  function automatic logic [FS+IS:0] fn(input logic [7:0] op, input logic [3*FS-1:0] f, input logic [IS-1:0] i);
    return {f[31:0] < f[63:32], (f[31:0] ^ f[95:64]) + f[63:32] + {24'b0, op}, (i + {8'b0, op}) ^ 16'h5a5a};
  endfunction
  always @(posedge clk) stub_cnt <= au_enable ? stub_cnt + 1 : 0;
  assign au_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : stub_cnt >= LAT;
  assign {au_cmp_flag, au_flt_out, au_int_out} =
    fn({au_ctrl_flag, au_opcode}, {au_flt_in3, au_flt_in2, au_flt_in1}, au_int_in);

  task automatic cmp(input string n, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask

  // Model: one op in flight; response cycle derived from the stub's ready rule and the watchdog limit
  task automatic check();
    logic [1:0] ea;
    logic g, ee;
    int w;
    if (reset) begin
      pending = 0; last_g = 1; free_at = 0;
      cmp("reset_en", au_enable, 0);
      cmp("reset_rsp", rsp_valid, 0);
      cmp("reset_acc", req_accept, 0);
      cmp("reset_regs", {rsp_id, rsp_err, rsp_flt, rsp_int, rsp_cmp}, 0);
      cmp("reset_au", {au_ctrl_flag, au_opcode, au_flt_in3, au_flt_in2, au_flt_in1, au_int_in}, 0);
      return;
    end
    ee = pending && cyc > p_acc && cyc < p_due;
    cmp("au_enable", au_enable, ee);
    if (ee) cmp("au_operands", {au_ctrl_flag, au_opcode, au_flt_in3, au_flt_in2, au_flt_in1, au_int_in}, p_ops);
    cmp("rsp_valid", rsp_valid, pending && cyc == p_due);
    if (pending && cyc == p_due) begin
      cmp("rsp_id", rsp_id, p_id);
      cmp("rsp_err", rsp_err, p_err);
      cmp("rsp_result", {rsp_cmp, rsp_flt, rsp_int}, p_err ? '0 : p_res);
      if (t_on) cmp("tbl_err", rsp_err, t_err);
      pending = 0;
      free_at = cyc + 1;
    end
    ea = 0;
    g = 0;
    if (!pending && cyc >= free_at && req_valid != 0) begin
      g = &req_valid ? !last_g : req_valid[1];
      ea = g ? 2'b10 : 2'b01;
    end
    cmp("req_accept", req_accept, ea);
    if (ea != 0) begin
      if (t_on) cmp("tbl_grant", req_accept, t_acc);
      n_acc++;
      last_g = g; pending = 1; p_acc = cyc; p_id = g;
      p_ops = g ? {req1_op, req1_flt, req1_int} : {req0_op, req0_flt, req0_int};
      p_res = fn(p_ops[119:112], p_ops[111:16], p_ops[15:0]);
      w = mode == 1 ? 0 : mode == 2 ? TO : LAT - 1;
      p_err = w >= TO;
      p_due = cyc + 3 + (p_err ? TO - 1 : w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && pending; k++) tick();
    cmp("idle_wait", pending, 0);
  endtask

  typedef struct {
    logic [1:0] valid;
    int mode;
    logic [7:0] op;
    logic [95:0] flt;
    logic [15:0] iv;
    logic [1:0] acc;
    bit err;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{2'b01, 0, 8'h40, {32'h42600000, 32'hC4094000, 32'h43A20000}, 16'd123, 2'b01, 0};
    tbl[1] = '{2'b11, 1, 8'h85, {32'h3F800000, 32'h40000000, 32'h40400000}, 16'd7, 2'b10, 0};
    tbl[2] = '{2'b11, 1, 8'hC3, {32'h11111111, 32'h22222222, 32'h33333333}, 16'hFFFF, 2'b01, 0};
    tbl[3] = '{2'b10, 2, 8'h01, {32'hDEADBEEF, 32'h0, 32'h1}, 16'd0, 2'b10, 1};
    tbl[4] = '{2'b01, 0, 8'h3F, {32'h7F800000, 32'hFF800000, 32'h0}, 16'h8000, 2'b01, 0};
    tbl[5] = '{2'b11, 2, 8'h22, {32'h1, 32'h2, 32'h3}, 16'd42, 2'b10, 1};
    tbl[6] = '{2'b11, 1, 8'h99, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF}, 16'd9, 2'b01, 0};
    reset = 1;
    repeat (3) tick();
    reset = 0;
    t_on = 1;
    foreach (tbl[i]) begin
      mode = tbl[i].mode; t_acc = tbl[i].acc; t_err = tbl[i].err;
      req0_op = tbl[i].op; req0_flt = tbl[i].flt; req0_int = tbl[i].iv;
      req1_op = ~tbl[i].op; req1_flt = ~tbl[i].flt; req1_int = tbl[i].iv + 16'd1;
      req_valid = tbl[i].valid;
      for (int k = 0; k < 20 && !pending; k++) tick();
      cmp("accept_wait", pending, 1);
      req_valid = 0;
      wait_idle();
    end
    t_on = 0;
    // both held with ready always high: alternating grants every 4 cycles, stale SETTLE ready ignored
    mode = 1; n_acc = 0; req_valid = 2'b11;
    repeat (24) tick();
    cmp("issue_rate", n_acc, 6);
    req_valid = 0;
    wait_idle();
    // requester 1 changes operands right after accept
    mode = 0; req1_flt = {32'h40490FDB, 32'hBF800000, 32'h3DCCCCCD}; req1_op = 8'h47; req1_int = 16'd555;
    req_valid = 2'b10;
    for (int k = 0; k < 20 && !pending; k++) tick();
    cmp("accept_wait", pending, 1);
    req_valid = 0; req1_flt = ~req1_flt; req1_op = 8'h00; req1_int = 16'd0;
    wait_idle();
    // reset in the middle of WAIT drops the op
    mode = 2; req_valid = 2'b01;
    for (int k = 0; k < 20 && !pending; k++) tick();
    cmp("accept_wait", pending, 1);
    req_valid = 0;
    repeat (3) tick();
    reset = 1;
    #1;
    cmp("rst_async_en", au_enable, 0);
    repeat (2) tick();
    reset = 0;
    repeat (12) tick();
    t_on = 1; t_acc = 2'b01; t_err = 0; mode = 1; req_valid = 2'b11;
    for (int k = 0; k < 20 && !pending; k++) tick();
    cmp("accept_wait", pending, 1);
    req_valid = 0;
    wait_idle();
    t_on = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pending) mode = $urandom_range(0, 2);
      req_valid = 2'($urandom_range(0, 3));
      req0_op = 8'($urandom); req1_op = 8'($urandom);
      req0_flt = {$urandom, $urandom, $urandom}; req1_flt = {$urandom, $urandom, $urandom};
      req0_int = 16'($urandom); req1_int = 16'($urandom);
      tick();
    end
    req_valid = 0;
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
